// File: rtl/recv.sv
// 8N1 UART receiver with oversampled mid-bit sampling and a valid/ack handshake.
// Optional build macro RECV_MAJORITY_EN: 2-of-3 majority vote around each mid-bit sample.
module recv #(
  parameter int CLKFREQ    = 12_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxpin,
  input  logic       ack,
  output logic [7:0] char,
  output logic       rxvalid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = CLKFREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);
`ifdef RECV_MAJORITY_EN
  // Decisions land one tick late so the third vote (tick N+1) is available.
  localparam int START_N = OVERSAMPLE / 2 + 1;
`else
  localparam int START_N = OVERSAMPLE / 2;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;

  state_t          state_q;
  logic            sync1_q, sync2_q;
  logic [CW-1:0]   cnt_q;
  logic [TW-1:0]   tcnt_q;
  logic [2:0]      bitn_q;
  logic [7:0]      shift_q;
  logic [7:0]      char_q;
  logic            rxvalid_q;
  logic            frame_err_q;
  logic            overrun_q;
  logic            rxs;
  logic            tick;
  logic            samp;

  assign rxs  = sync2_q;
  assign tick = (cnt_q == CW'(DIV - 1));

`ifdef RECV_MAJORITY_EN
  logic [1:0] vote_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign samp = maj3(vote_q[1], vote_q[0], rxs);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    vote_q <= 2'b11;
    else if (tick) vote_q <= {vote_q[0], rxs};
  end
`else
  assign samp = rxs;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxpin;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      bitn_q      <= '0;
      shift_q     <= '0;
      char_q      <= '0;
      rxvalid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      cnt_q       <= tick ? '0 : cnt_q + 1'b1;
      if (ack && rxvalid_q) begin
        rxvalid_q <= 1'b0;
        overrun_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          tcnt_q <= '0;
          bitn_q <= '0;
          if (!rxs) state_q <= START;
        end
        START: if (tick) begin
          if (tcnt_q == TW'(START_N - 1)) begin
            tcnt_q  <= '0;
            state_q <= samp ? IDLE : DATA;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        DATA: if (tick) begin
          if (tcnt_q == TW'(OVERSAMPLE - 1)) begin
            tcnt_q  <= '0;
            shift_q <= {samp, shift_q[7:1]};
            bitn_q  <= bitn_q + 1'b1;
            if (bitn_q == 3'd7) state_q <= STOP;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        STOP: if (tick) begin
          if (tcnt_q == TW'(OVERSAMPLE - 1)) begin
            tcnt_q <= '0;
            if (samp) begin
              char_q    <= shift_q;
              rxvalid_q <= 1'b1;
              // An ack on the completing edge consumes the old byte, so no overrun.
              if (ack)            overrun_q <= 1'b0;
              else if (rxvalid_q) overrun_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAITHI;
            end
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        WAITHI: if (rxs) begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign char      = char_q;
  assign rxvalid   = rxvalid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_recv.sv
// Directed bench for recv at 12 MHz / 115200 baud / 4x oversampling (104 clk per bit).
module tb_recv;

  localparam int BITC = 104;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxpin = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] char_o;
  logic       rxvalid, busy, frame_err, overrun;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int ferr_seen = 0;
  int rise;

  recv #(.CLKFREQ(12_000_000), .BAUD(115200), .OVERSAMPLE(4)) dut (
    .clk(clk), .reset(reset), .rxpin(rxpin), .ack(ack),
    .char(char_o), .rxvalid(rxvalid), .busy(busy),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (frame_err) ferr_seen++;
  endtask

  task automatic hold(input int n, input logic lvl);
    for (int i = 0; i < n; i++) begin
      rxpin = lvl;
      step();
    end
  endtask

  // Drives the first len clocks of a frame; rise = clocks from start edge to rxvalid 0->1.
  task automatic send(input logic [7:0] d, input logic stopb, input int len,
                      input int glitch_at, output int rise_o);
    logic [9:0] fb;
    logic       prev;
    fb     = {stopb, d, 1'b0};
    rise_o = -1;
    prev   = rxvalid;
    for (int i = 0; i < len; i++) begin
      rxpin = fb[i / BITC];
      if (i == glitch_at) rxpin = ~rxpin;
      step();
      if (!prev && rxvalid && rise_o < 0) rise_o = i + 1;
      prev = rxvalid;
    end
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    check("rst_char", char_o, 8'h00);
    check("rst_rxvalid", rxvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    reset = 1'b1;
    hold(20, 1'b1);

    // Byte 0x55, no ack
    ferr_seen = 0;
    send(8'h55, 1'b1, 10 * BITC, -1, rise);
    check("t1_char", char_o, 8'h55);
    check("t1_rxvalid", rxvalid, 1'b1);
    check("t1_latency_window", (rise >= 985 && rise <= 995), 1'b1);
    check("t1_frame_err", ferr_seen, 0);
    check("t1_overrun", overrun, 1'b0);
    check("t1_busy", busy, 1'b0);
    ack_pulse();
    check("t1_ack_clears", rxvalid, 1'b0);

    // Byte 0x41 then single-cycle ack
    send(8'h41, 1'b1, 10 * BITC, -1, rise);
    check("t2_char", char_o, 8'h41);
    check("t2_rxvalid", rxvalid, 1'b1);
    ack = 1'b1;
    step();
    check("t2_rxvalid_after_ack", rxvalid, 1'b0);
    ack = 1'b0;
    check("t2_busy_idle", busy, 1'b0);
    ack_pulse();
    check("t2_ack_noeffect_rv", rxvalid, 1'b0);
    check("t2_ack_noeffect_char", char_o, 8'h41);

    // Short start-bit glitch
    ferr_seen = 0;
    hold(30, 1'b0);
    check("t3_busy_in_start", busy, 1'b1);
    hold(150, 1'b1);
    check("t3_busy_back_idle", busy, 1'b0);
    check("t3_rxvalid", rxvalid, 1'b0);
    check("t3_frame_err", ferr_seen, 0);

    // Framing error then stuck-low line
    ferr_seen = 0;
    send(8'hA3, 1'b0, 10 * BITC, -1, rise);
    hold(500, 1'b0);
    check("t4_frame_err_pulses", ferr_seen, 1);
    check("t4_rxvalid", rxvalid, 1'b0);
    check("t4_char_kept", char_o, 8'h41);
    check("t4_busy_low_line", busy, 1'b1);
    hold(5, 1'b1);
    check("t4_busy_released", busy, 1'b0);

    // Back-to-back frames without ack -> overrun
    send(8'h11, 1'b1, 10 * BITC, -1, rise);
    check("t5_char1", char_o, 8'h11);
    check("t5_overrun_first", overrun, 1'b0);
    send(8'h22, 1'b1, 10 * BITC, -1, rise);
    check("t5_char2", char_o, 8'h22);
    check("t5_rxvalid", rxvalid, 1'b1);
    check("t5_overrun", overrun, 1'b1);
    ack_pulse();
    check("t5_ack_rxvalid", rxvalid, 1'b0);
    check("t5_ack_overrun", overrun, 1'b0);

    // Reset during bit 4 of 0xFF, then a clean 0x0F
    send(8'hFF, 1'b1, 5 * BITC + 50, -1, rise);
    reset = 1'b0;
    step();
    step();
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_char", char_o, 8'h00);
    reset = 1'b1;
    hold(600, 1'b1);
    check("t6_partial_not_delivered", rxvalid, 1'b0);
    ferr_seen = 0;
    send(8'h0F, 1'b1, 10 * BITC, -1, rise);
    check("t6_char", char_o, 8'h0F);
    check("t6_rxvalid", rxvalid, 1'b1);
    check("t6_frame_err", ferr_seen, 0);
    ack_pulse();

`ifdef RECV_MAJORITY_EN
    // One-clock glitch at the middle of data bit 2
    send(8'h00, 1'b1, 10 * BITC, 3 * BITC + 52, rise);
    check("maj_char", char_o, 8'h00);
    check("maj_rxvalid", rxvalid, 1'b1);
    ack_pulse();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
